// File: rtl/iomem_gpio_pkg.sv
// iomem_gpio_pkg: register map and default base address for the GPIO block
package iomem_gpio_pkg;
  typedef enum logic [1:0] {
    REG_OUT    = 2'd0,
    REG_IN     = 2'd1,
    REG_EDGE   = 2'd2,
    REG_IRQ_EN = 2'd3
  } reg_e;
  localparam logic [7:0] DEF_BASE_ADDR = 8'h03;
endpackage

// File: rtl/iomem_gpio_if.sv
// iomem_gpio_if: iomem bus bundle with master and slave views
interface iomem_gpio_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  modport master (output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, input iomem_ready, iomem_rdata);
  modport slave (input iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, output iomem_ready, iomem_rdata);
endinterface

// File: rtl/iomem_gpio_debounce.sv
// gpio_debounce: two-flop synchroniser plus tick-sampled debouncer (debouncer present only with IOMEM_GPIO_DEBOUNCE_EN)
module gpio_debounce #(
  parameter int W = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_range
    $error("DEBOUNCE_CYCLES out of range");
  end
  logic [W-1:0] s1_q, s2_q;
  // synchronise the raw asynchronous inputs before anything looks at them
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
`ifdef IOMEM_GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  samp_q, samp_d, db_q, db_d, agree;
  logic          tick;
  // a bit follows the input only once two successive tick samples agree on a new value
  always_comb begin
    tick   = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d  = tick ? '0 : cnt_q + CW'(1);
    agree  = ~(s2_q ^ samp_q);
    samp_d = tick ? s2_q : samp_q;
    db_d   = tick ? (agree & s2_q) | (~agree & db_q) : db_q;
  end
  // tick counter, sample history and debounced state
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt_q  <= '0;
      samp_q <= '0;
      db_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      samp_q <= samp_d;
      db_q   <= db_d;
    end
  assign q = db_q;
`else
  assign q = s2_q;
`endif
endmodule

// File: rtl/iomem_gpio.sv
// iomem_gpio: iomem-mapped GPIO with OUT/IN/EDGE/IRQ_EN registers; IOMEM_GPIO_DEBOUNCE_EN enables switch debouncing
module iomem_gpio
  import iomem_gpio_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         resetn,
  iomem_gpio_if.slave  bus,
  input  logic [7:0]   sw,
  output logic [7:0]   led,
  output logic         irq
);
  logic [31:0] out_q, out_d, rdata_q, rdata_d;
  logic [7:0]  edge_q, edge_d, irq_en_q, irq_en_d, prev_q, prev_d, db, clr;
  logic        ready_q, ready_d, sel, wr;
  reg_e        rsel;
  logic        unused;
  assign unused = ^{bus.iomem_addr[23:4], bus.iomem_addr[1:0]};
  gpio_debounce #(.W(8), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(clk), .resetn(resetn), .d(sw), .q(db)
  );
  // bus decode, register updates and read mux; sticky edge set beats a simultaneous clear
  always_comb begin
    sel     = bus.iomem_valid && !ready_q && bus.iomem_addr[31:24] == BASE_ADDR;
    wr      = sel && |bus.iomem_wstrb;
    rsel    = reg_e'(bus.iomem_addr[3:2]);
    ready_d = sel;
    out_d   = out_q;
    for (int i = 0; i < 4; i++)
      out_d[8*i+:8] = wr && rsel == REG_OUT && bus.iomem_wstrb[i] ? bus.iomem_wdata[8*i+:8] : out_q[8*i+:8];
    clr      = wr && rsel == REG_EDGE && bus.iomem_wstrb[0] ? bus.iomem_wdata[7:0] : 8'h00;
    edge_d   = (edge_q & ~clr) | (db & ~prev_q);
    prev_d   = db;
    irq_en_d = wr && rsel == REG_IRQ_EN && bus.iomem_wstrb[0] ? bus.iomem_wdata[7:0] : irq_en_q;
    rdata_d  = !sel ? rdata_q :
               rsel == REG_OUT  ? out_q :
               rsel == REG_IN   ? {24'b0, db} :
               rsel == REG_EDGE ? {24'b0, edge_q} : {24'b0, irq_en_q};
  end
  // register state; reset also aborts any access in flight
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      out_q    <= '0;
      edge_q   <= '0;
      irq_en_q <= '0;
      prev_q   <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      out_q    <= out_d;
      edge_q   <= edge_d;
      irq_en_q <= irq_en_d;
      prev_q   <= prev_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
    end
  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign led = out_q[7:0];
  assign irq = |(edge_q & irq_en_q);
endmodule

// File: tb/tb_iomem_gpio.sv
// tb_iomem_gpio: directed table-driven bench for iomem_gpio plus edge, debounce and reset sequences
module tb_iomem_gpio;
  logic clk = 1'b0, resetn = 1'b0, irq;
  logic [7:0] sw = 8'h00, led;
  int checks = 0, errors = 0, cyc = 0;
`ifdef IOMEM_GPIO_DEBOUNCE_EN
  localparam int LO = 7, HI = 13, SETK = 9;
`else
  localparam int LO = 2, HI = 5, SETK = 3;
`endif
  iomem_gpio_if bus();
  iomem_gpio #(.BASE_ADDR(8'h03), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .sw(sw), .led(led), .irq(irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  led;
    logic        irq;
  } vec_t;
  vec_t v[15];
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, output logic [31:0] r, output bit ok);
    bus.iomem_addr  = a;
    bus.iomem_wstrb = s;
    bus.iomem_wdata = d;
    bus.iomem_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (bus.iomem_ready) ok = 1'b1;
    end
    r = bus.iomem_rdata;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    logic [31:0] r;
    bit ok, found;
    int c0, el;
    v[0]  = '{32'h03000000, 4'b0001, 32'h000000A5, 32'h00000000, 8'hA5, 1'b0};
    v[1]  = '{32'h03000000, 4'b0000, 32'h00000000, 32'h000000A5, 8'hA5, 1'b0};
    v[2]  = '{32'h03000000, 4'b0100, 32'hFFFFFFFF, 32'h000000A5, 8'hA5, 1'b0};
    v[3]  = '{32'h03ABCDE3, 4'b0000, 32'h00000000, 32'h00FF00A5, 8'hA5, 1'b0};
    v[4]  = '{32'h03000004, 4'b1111, 32'hFFFFFFFF, 32'h00000000, 8'hA5, 1'b0};
    v[5]  = '{32'h03000004, 4'b0000, 32'h00000000, 32'h00000000, 8'hA5, 1'b0};
    v[6]  = '{32'h0300000C, 4'b0001, 32'hFFFFFFFF, 32'h00000000, 8'hA5, 1'b0};
    v[7]  = '{32'h0300000C, 4'b0000, 32'h00000000, 32'h000000FF, 8'hA5, 1'b0};
    v[8]  = '{32'h0300000C, 4'b0010, 32'h00000000, 32'h000000FF, 8'hA5, 1'b0};
    v[9]  = '{32'h0300000C, 4'b0001, 32'h00000101, 32'h000000FF, 8'hA5, 1'b0};
    v[10] = '{32'h037FFFFC, 4'b0000, 32'h00000000, 32'h00000001, 8'hA5, 1'b0};
    v[11] = '{32'h03000008, 4'b0000, 32'h00000000, 32'h00000000, 8'hA5, 1'b0};
    v[12] = '{32'h03000000, 4'b1000, 32'h12345678, 32'h00FF00A5, 8'hA5, 1'b0};
    v[13] = '{32'h03000000, 4'b0001, 32'h0000003C, 32'h12FF00A5, 8'h3C, 1'b0};
    v[14] = '{32'h03000000, 4'b0000, 32'h00000000, 32'h12FF003C, 8'h3C, 1'b0};
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_addr  = '0;
    bus.iomem_wdata = '0;
    #1;
    check("reset led", led, 0);
    check("reset irq", irq, 0);
    check("reset ready", bus.iomem_ready, 0);
    check("reset rdata", bus.iomem_rdata, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      xfer(v[i].addr, v[i].wstrb, v[i].wdata, r, ok);
      check($sformatf("v%0d ready", i), ok, 1);
      check($sformatf("v%0d rdata", i), r, v[i].rdata);
      @(posedge clk);
      #1;
      check($sformatf("v%0d ready drop", i), bus.iomem_ready, 0);
      check($sformatf("v%0d led", i), led, v[i].led);
      check($sformatf("v%0d irq", i), irq, v[i].irq);
    end
    xfer(32'h04000000, 4'hF, 32'hFFFFFFFF, r, ok);
    check("unselected ready", ok, 0);
    xfer(32'h03000000, 4'h0, 32'h0, r, ok);
    check("unselected out", r, 32'h12FF003C);
    check("unselected led", led, 8'h3C);
    sw = 8'h01;
    c0 = cyc;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      xfer(32'h03000004, 4'h0, 32'h0, r, ok);
      if (ok && r == 32'h1) found = 1'b1;
    end
    el = cyc - c0;
    check("in rise seen", found, 1);
    check("in rise latency window", el >= LO && el <= HI, 1);
    xfer(32'h03000008, 4'h0, 32'h0, r, ok);
    check("edge set", r, 32'h1);
    check("irq high", irq, 1);
    xfer(32'h03000008, 4'h1, 32'h1, r, ok);
    check("irq cleared", irq, 0);
    xfer(32'h03000008, 4'h0, 32'h0, r, ok);
    check("edge w1c", r, 32'h0);
`ifdef IOMEM_GPIO_DEBOUNCE_EN
    sw = 8'h03;
    repeat (3) @(posedge clk);
    #1 sw = 8'h01;
    repeat (24) @(posedge clk);
    #1;
    xfer(32'h03000004, 4'h0, 32'h0, r, ok);
    check("glitch in", r, 32'h1);
    xfer(32'h03000008, 4'h0, 32'h0, r, ok);
    check("glitch edge", r, 32'h0);
`endif
    bus.iomem_addr  = 32'h03000000;
    bus.iomem_wstrb = 4'h1;
    bus.iomem_wdata = 32'h55;
    bus.iomem_valid = 1'b1;
    #3 resetn = 1'b0;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    #1;
    check("abort led", led, 0);
    check("abort irq", irq, 0);
    check("abort rdata", bus.iomem_rdata, 0);
    @(posedge clk);
    #1;
    check("abort ready", bus.iomem_ready, 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (SETK - 1) @(posedge clk);
    #1;
    xfer(32'h03000008, 4'h1, 32'h1, r, ok);
    check("coincide ready", ok, 1);
    xfer(32'h03000008, 4'h0, 32'h0, r, ok);
    check("set wins over clear", r, 32'h1);
    xfer(32'h03000000, 4'h0, 32'h0, r, ok);
    check("abort out", r, 32'h0);
    xfer(32'h0300000C, 4'h0, 32'h0, r, ok);
    check("abort irq_en", r, 32'h0);
    check("post reset irq", irq, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
